// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-port word memory.
// Data wins by default; a saturating starvation counter eventually forces a fetch grant.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } own_e;

  own_e       own_q, own_d;
  logic       err_q, err_d;
  logic       st_q, st_d;
  logic [3:0] starve_q, starve_d;
  logic       d_pri;
  logic       i_ok, d_ok;
  logic       unused_addr_lsb;

  // Every bit above the word-address field must be zero.
  function automatic logic in_range(input logic [31:0] addr);
    return (addr >> (ADDR_W + 2)) == 32'd0;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= STARVE_LIM) ? STARVE_LIM : cnt + 4'd1;
  endfunction

  assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

  // Stage 0: selection, range check and memory command (combinational)
  assign i_ok  = in_range(i_addr);
  assign d_ok  = in_range(d_addr);
  assign d_pri = d_req && (starve_q < STARVE_LIM);

  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_be    = 4'd0;
    m_addr  = '0;
    m_wdata = 32'd0;
    if (!rst) begin
      if (d_pri) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
    if (i_gnt) begin
      m_en   = i_ok;
      m_addr = i_addr[ADDR_W+1:2];
    end else if (d_gnt) begin
      m_en    = d_ok;
      m_we    = d_ok && d_we;
      m_be    = (d_ok && d_we) ? d_be : 4'd0;
      m_addr  = d_addr[ADDR_W+1:2];
      m_wdata = d_wdata;
    end
  end

  always_comb begin
    starve_d = 4'd0;
    if (i_req && !i_gnt) begin
      starve_d = sat_inc(starve_q);
    end
  end

  always_comb begin
    own_d = OWN_NONE;
    err_d = 1'b0;
    st_d  = 1'b0;
    if (i_gnt) begin
      own_d = OWN_FETCH;
      err_d = !i_ok;
    end else if (d_gnt) begin
      own_d = OWN_DATA;
      err_d = !d_ok;
      st_d  = d_we;
    end
  end

  // Stage 1: response ownership register
  always_ff @(posedge clk) begin
    if (rst) begin
      own_q    <= OWN_NONE;
      starve_q <= 4'd0;
    end else begin
      own_q    <= own_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    err_q <= err_d;
    st_q  <= st_d;
  end

  // Response data comes straight from the memory read port, gated by ownership.
  always_comb begin
    i_rvalid = (own_q == OWN_FETCH);
    d_rvalid = (own_q == OWN_DATA);
    i_err    = i_rvalid && err_q;
    d_err    = d_rvalid && err_q;
    i_rdata  = (i_rvalid && !err_q) ? m_rdata : 32'd0;
    d_rdata  = (d_rvalid && !err_q && !st_q) ? m_rdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: tasks issue requests and queue expected responses,
// a negedge monitor retires responses in order and checks one-cycle response latency.
module tb_mem_arbiter;
  localparam int ADDR_W     = 16;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req = 1'b0;
  logic [31:0]       i_addr = 32'd0;
  logic              i_gnt, i_rvalid, i_err;
  logic [31:0]       i_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [3:0]        d_be = 4'd0;
  logic [31:0]       d_addr = 32'd0;
  logic [31:0]       d_wdata = 32'd0;
  logic              d_gnt, d_rvalid, d_err;
  logic [31:0]       d_rdata;
  logic              m_en, m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write-before-read, contents restored on reset.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h1000_0000 + 32'(k);
      mem[4]  <= 32'h0000_0513;
      mem[8]  <= 32'h1122_3344;
      m_rdata <= 32'd0;
    end else if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem[m_addr[7:0]][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= mem[m_addr[7:0]];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [32:0] iq[$];
  logic [32:0] dq[$];
  logic [1:0]  glog[$];
  logic        log_en = 1'b0;
  logic        mon_en = 1'b0;
  logic        prev_ig = 1'b0;
  logic        prev_dg = 1'b0;

  always @(negedge clk) begin
    if (log_en) glog.push_back({i_gnt, d_gnt});
  end

  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (mon_en) begin
      if (prev_ig || i_rvalid) chk("i_rvalid_latency", 128'(i_rvalid), 128'(prev_ig));
      if (prev_dg || d_rvalid) chk("d_rvalid_latency", 128'(d_rvalid), 128'(prev_dg));
      if (i_rvalid) begin
        if (iq.size() == 0) chk("i_resp_unexpected", 128'(1), 128'(0));
        else begin
          e = iq.pop_front();
          chk("i_resp_err_data", 128'({i_err, i_rdata}), 128'(e));
        end
      end
      if (d_rvalid) begin
        if (dq.size() == 0) chk("d_resp_unexpected", 128'(1), 128'(0));
        else begin
          e = dq.pop_front();
          chk("d_resp_err_data", 128'({d_err, d_rdata}), 128'(e));
        end
      end
    end
    prev_ig <= i_gnt;
    prev_dg <= d_gnt;
  end

  task automatic fetch(input logic [31:0] addr, input logic exp_err, input logic [31:0] exp_data);
    bit got = 0;
    i_req  = 1'b1;
    i_addr = addr;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (i_gnt) begin
        got = 1;
        chk("f_m_en", 128'(m_en), 128'(!exp_err));
        chk("f_m_we_be", 128'({m_we, m_be}), 128'(0));
        if (!exp_err) chk("f_m_addr", 128'(m_addr), 128'(addr[17:2]));
        iq.push_back({exp_err, exp_data});
      end
      @(posedge clk); #1;
    end
    i_req  = 1'b0;
    i_addr = 32'd0;
    if (!got) chk("f_gnt_timeout", 128'(0), 128'(1));
  endtask

  task automatic d_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_data);
    bit got = 0;
    d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (d_gnt) begin
        got = 1;
        chk("d_m_en", 128'(m_en), 128'(!exp_err));
        chk("d_m_we_be", 128'({m_we, m_be}), (!exp_err && we) ? 128'({1'b1, be}) : 128'(0));
        if (!exp_err) chk("d_m_addr", 128'(m_addr), 128'(addr[17:2]));
        if (!exp_err && we) chk("d_m_wdata", 128'(m_wdata), 128'(wdata));
        dq.push_back({exp_err, exp_data});
      end
      @(posedge clk); #1;
    end
    d_req = 1'b0; d_we = 1'b0; d_be = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
    if (!got) chk("d_gnt_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] pat [0:10];
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    repeat (5) begin
      @(negedge clk);
      chk("idle_outputs", 128'({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, m_en, m_we,
                                m_be, m_addr, m_wdata, i_rdata, d_rdata}), 128'(0));
    end
    @(posedge clk); #1;

    fetch(32'h0000_0010, 1'b0, 32'h0000_0513);
    d_access(1'b1, 4'b0011, 32'h0000_0020, 32'hAABB_CCDD, 1'b0, 32'd0);
    d_access(1'b0, 4'b0000, 32'h0000_0020, 32'd0, 1'b0, 32'h1122_CCDD);

    log_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 9; k++)
          d_access(1'b0, 4'b0000, 32'h40 + 32'(4 * k), 32'd0, 1'b0, 32'h1000_0010 + 32'(k));
      end
      begin
        fetch(32'h0000_0010, 1'b0, 32'h0000_0513);
        fetch(32'h0000_0014, 1'b0, 32'h1000_0005);
      end
    join
    log_en = 1'b0;
    chk("grant_log_len", 128'(glog.size()), 128'(11));
    for (int k = 0; k < 11 && k < glog.size(); k++)
      chk($sformatf("grant_pattern_%0d", k), 128'(glog[k]), 128'(pat[k]));

    d_access(1'b0, 4'b0000, 32'h0004_0000, 32'd0, 1'b1, 32'd0);
    d_access(1'b1, 4'b1111, 32'h0004_0000, 32'hDEAD_BEEF, 1'b1, 32'd0);
    fetch(32'h8000_0000, 1'b1, 32'd0);

    rst = 1'b1; i_req = 1'b1; i_addr = 32'h0000_0010;
    @(negedge clk);
    chk("rst_gnt_suppressed", 128'({i_gnt, d_gnt, m_en}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    fork
      fetch(32'h0000_0010, 1'b0, 32'h0000_0513);
      begin
        @(negedge clk);
        chk("rst_no_rvalid", 128'({i_rvalid, d_rvalid}), 128'(0));
      end
    join

    repeat (3) @(negedge clk);
    chk("iq_drained", 128'(iq.size()), 128'(0));
    chk("dq_drained", 128'(dq.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the core's single-port unified word memory between the instruction-fetch path and the load/store path. It sits between the pipeline front end / memory stage and the memory array, grants at most one access per cycle, and returns the response on the owning port one cycle later. Data accesses win by default. A starvation counter forces an instruction grant after a bounded wait. Out-of-range addresses are answered with an error instead of touching memory.

## Interface
- ADDR_W, 16, word-address width of the memory array (2^ADDR_W 32-bit words)
- STARVE_MAX, 4, consecutive denied cycles of i_req after which the fetch port wins (1..15)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  32  fetch byte address (bits [1:0] ignored)
- i_gnt  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  fetch response valid (registered)
- i_rdata  out  32  fetch read data, valid with i_rvalid
- i_err  out  1  fetch address out of range, valid with i_rvalid
- d_req  in  1  load/store request; held with the remaining d_* inputs stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  32  data byte address (bits [1:0] ignored)
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data response valid: load data or store acknowledge (registered)
- d_rdata  out  32  load data, valid with d_rvalid; 0 for stores
- d_err  out  1  data address out of range, valid with d_rvalid
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_be  out  4  memory byte enables
- m_addr  out  ADDR_W  memory word address = addr[ADDR_W+1:2]
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data; valid one cycle after m_en with m_we=0

## Operation
- Selection each cycle, combinational:
  - If d_req is high and starve_cnt < STARVE_MAX, data is selected.
  - Otherwise, if i_req is high, fetch is selected.
  - Otherwise, if d_req is high, data is selected.
- Exactly the selected port's gnt is high; both are 0 when neither port requests.
- Range check: addr[31:ADDR_W+2] must be all zero.
  - In-range grant: m_en=1, m_we = d_we for data and 0 for fetch, m_be = d_be for data stores and 0 otherwise, m_addr and m_wdata driven from the granted port.
  - Out-of-range grant: m_en=0, m_we=0; the response carries err=1 and rdata=0.
- When no grant is issued, m_en, m_we and m_be are 0; m_addr and m_wdata hold 0.
- Response register, captured at the grant edge: owner (NONE/FETCH/DATA), err, is_store. One response is pending at most, and it retires in the next cycle.
- Response cycle:
  - Owner FETCH: i_rvalid=1; i_rdata = m_rdata, or 0 on error.
  - Owner DATA: d_rvalid=1; d_rdata = m_rdata for an in-range load, 0 for a store or an error.
- starve_cnt, 4 bits:
  - Increments when i_req is high and i_gnt is low.
  - Clears to 0 on i_gnt or when i_req is low.
  - Saturates at STARVE_MAX.
- Back-to-back grants are legal every cycle. Request N+1 may be granted in the same cycle that the response to N is presented.

## Timing
- Grant latency: 0 cycles (gnt in the same cycle as req when selected).
- Response latency: exactly 1 cycle after the grant, for reads, writes and errors.
- Throughput: one access per cycle.
- Reset state: i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, m_en, m_we = 0; m_be, m_addr, m_wdata, i_rdata, d_rdata = 0; owner = NONE; starve_cnt = 0.
- Reset mid-operation: a grant issued in a cycle where rst=1 is suppressed (gnt=0, m_en=0). A response pending at the reset edge is dropped, so no rvalid appears in the cycle after reset.
- Simultaneous i_req and d_req with starve_cnt=STARVE_MAX: fetch is granted, starve_cnt clears, and data waits exactly one cycle.
- A store followed by a load to the same word on consecutive cycles must return the new data; this relies on memory write-before-read ordering and needs no forwarding.

## Test plan
- Reset then idle: rst high for 2 cycles then low with no requests → all outputs 0 for 5 cycles, m_en never asserted.
- Single fetch: i_req with i_addr=0x0000_0010 and mem[4]=0x0000_0513 → i_gnt same cycle, m_addr=4; next cycle i_rvalid=1, i_rdata=0x0000_0513, i_err=0.
- Store then load: store d_addr=0x20, d_be=4'b0011, d_wdata=0xAABB_CCDD over mem[8]=0x1122_3344 → d_rvalid ack with d_rdata=0. A load of 0x20 next cycle returns 0x1122_CCDD.
- Contention and starvation with STARVE_MAX=4: hold d_req and i_req high continuously → grant pattern D,D,D,D,I repeating; every i_rvalid and d_rvalid appears one cycle after its grant.
- Out of range: d_req load at d_addr=0x0004_0000 (ADDR_W=16) → d_gnt=1, m_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
- Reset mid-access: assert rst in the cycle of an i_gnt → no i_rvalid the following cycle; the first grant after rst deasserts behaves as in the single-fetch case.
